// File: rtl/lab2_1_pkg.sv
// ============================================================================
// Module   : lab2_1_pkg
// Brief    : Shared constants and state encoding for the lab2_1 bouncing
//            counter and its receiving-end monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lab2_1_pkg;

    localparam logic [5:0] TOP        = 6'd63;
    localparam logic [5:0] START_STEP = 6'd1;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        TRACK  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/lab2_1_step.sv
// ============================================================================
// Module   : lab2_1_step
// Brief    : Combinational next-value rule of the lab2_1 bouncing counter.
//            Shared between the monitor and the counter generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lab2_1_step
    import lab2_1_pkg::*;
(
    input  logic [5:0] cur,
    input  logic       dir,
    input  logic [5:0] step,
    output logic [5:0] next_val,
    output logic       next_dir,
    output logic [5:0] next_step,
    output logic       wrap
);

    logic [5:0] w_up_val;
    logic [5:0] w_down_val;

    // Up phase bounces around cur; down phase subtracts rising powers of two.
    assign w_up_val   = (cur > step) ? (cur - step) : (cur + step);
    assign w_down_val = cur - (6'd1 << step);

    always_comb begin
        next_val  = w_up_val;
        next_dir  = 1'b0;
        next_step = step + 6'd1;
        wrap      = 1'b0;
        if (!dir) begin
            next_val = w_up_val;
            if (w_up_val == TOP) begin
                next_dir  = 1'b1;
                next_step = 6'd0;
            end
        end else begin
            next_val = w_down_val;
            next_dir = 1'b1;
            if (w_down_val == 6'd0) begin
                next_dir  = 1'b0;
                next_step = START_STEP;
                wrap      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/lab2_1_monitor.sv
// ============================================================================
// Module   : lab2_1_monitor
// Brief    : Locks onto the lab2_1 counter stream at a 0 and checks every
//            following valid sample against the predicted value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lab2_1_monitor
    import lab2_1_pkg::*;
#(
    parameter int ERR_W = 8,
    parameter int PER_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [5:0]       in_data,
    output logic             locked,
    output logic [5:0]       expected,
    output logic             match,
    output logic             err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count,
    output logic             dir,
    output logic [5:0]       step,
    output logic             period_done,
    output logic [PER_W-1:0] periods
);

    localparam logic [ERR_W-1:0] c_ERR_ONE = ERR_W'(1);
    localparam logic [PER_W-1:0] c_PER_ONE = PER_W'(1);

    state_t           r_state;
    logic [5:0]       r_cur;
    logic             r_dir;
    logic [5:0]       r_step;
    logic             r_match;
    logic             r_err;
    logic             r_err_sticky;
    logic [ERR_W-1:0] r_err_count;
    logic             r_period_done;
    logic [PER_W-1:0] r_periods;

    logic [5:0]       w_next_val;
    logic             w_next_dir;
    logic [5:0]       w_next_step;
    logic             w_wrap;

    lab2_1_step u_step (
        .cur       (r_cur),
        .dir       (r_dir),
        .step      (r_step),
        .next_val  (w_next_val),
        .next_dir  (w_next_dir),
        .next_step (w_next_step),
        .wrap      (w_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= SEARCH;
            r_cur         <= 6'd0;
            r_dir         <= 1'b0;
            r_step        <= START_STEP;
            r_match       <= 1'b0;
            r_err         <= 1'b0;
            r_err_sticky  <= 1'b0;
            r_err_count   <= '0;
            r_period_done <= 1'b0;
            r_periods     <= '0;
        end else begin
            r_match       <= 1'b0;
            r_err         <= 1'b0;
            r_period_done <= 1'b0;
            if (in_valid) begin
                case (r_state)
                    SEARCH: begin
                        if (in_data == 6'd0) begin
                            r_state <= TRACK;
                            r_cur   <= 6'd0;
                            r_dir   <= 1'b0;
                            r_step  <= START_STEP;
                        end
                    end
                    TRACK: begin
                        if (in_data == w_next_val) begin
                            r_match <= 1'b1;
                            r_cur   <= w_next_val;
                            r_dir   <= w_next_dir;
                            r_step  <= w_next_step;
                            if (w_wrap) begin
                                r_period_done <= 1'b1;
                                if (r_periods != '1) begin
                                    r_periods <= r_periods + c_PER_ONE;
                                end
                            end
                        end else begin
                            r_err        <= 1'b1;
                            r_err_sticky <= 1'b1;
                            if (r_err_count != '1) begin
                                r_err_count <= r_err_count + c_ERR_ONE;
                            end
                            // A bad 0 is itself a valid lock point.
                            if (in_data == 6'd0) begin
                                r_state <= TRACK;
                                r_cur   <= 6'd0;
                                r_dir   <= 1'b0;
                                r_step  <= START_STEP;
                            end else begin
                                r_state <= SEARCH;
                            end
                        end
                    end
                    default: r_state <= SEARCH;
                endcase
            end
        end
    end

    assign locked      = (r_state == TRACK);
    assign expected    = locked ? w_next_val : 6'd0;
    assign match       = r_match;
    assign err         = r_err;
    assign err_sticky  = r_err_sticky;
    assign err_count   = r_err_count;
    assign dir         = r_dir;
    assign step        = r_step;
    assign period_done = r_period_done;
    assign periods     = r_periods;

endmodule

`default_nettype wire

// File: tb/tb_lab2_1_monitor.sv
// ============================================================================
// Module   : tb_lab2_1_monitor
// Brief    : Self-checking bench for lab2_1_monitor against a sequence-index
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lab2_1_monitor;

    localparam int ERR_W = 3;
    localparam int PER_W = 2;
    localparam int EMAX  = (1 << ERR_W) - 1;
    localparam int PMAX  = (1 << PER_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [5:0]       in_data;
    logic             locked;
    logic [5:0]       expected;
    logic             match;
    logic             err;
    logic             err_sticky;
    logic [ERR_W-1:0] err_count;
    logic             dir;
    logic [5:0]       step;
    logic             period_done;
    logic [PER_W-1:0] periods;

    always #5 clk = ~clk;

    lab2_1_monitor #(.ERR_W(ERR_W), .PER_W(PER_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .locked      (locked),
        .expected    (expected),
        .match       (match),
        .err         (err),
        .err_sticky  (err_sticky),
        .err_count   (err_count),
        .dir         (dir),
        .step        (step),
        .period_done (period_done),
        .periods     (periods)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", tag, got, exp);
    endtask

    // Reference: one period as a table; position m_pos indexes the next value.
    int seq [63];
    int down_tbl [6] = '{62, 60, 56, 48, 32, 0};
    bit m_locked, m_sticky, m_match, m_err, m_pd;
    int m_pos, m_errs, m_pers;

    function automatic int m_exp();
        return m_locked ? seq[m_pos] : 0;
    endfunction

    task automatic build_seq();
        int c = 0;
        int n = 1;
        int k = 0;
        while (1) begin
            c = (c > n) ? c - n : c + n;
            seq[k++] = c;
            if (c == 63) break;
            n++;
        end
        for (int p = 0; p < 6; p++) begin
            c = c - (1 << p);
            seq[k++] = c;
        end
    endtask

    task automatic model_step(input bit v, input int d);
        m_match = 0; m_err = 0; m_pd = 0;
        if (v) begin
            if (m_locked) begin
                if (d == seq[m_pos]) begin
                    m_match = 1;
                    if (m_pos == 62) begin
                        m_pos = 0;
                        m_pd  = 1;
                        if (m_pers < PMAX) m_pers++;
                    end else begin
                        m_pos++;
                    end
                end else begin
                    m_err    = 1;
                    m_sticky = 1;
                    if (m_errs < EMAX) m_errs++;
                    m_locked = (d == 0);
                    m_pos    = 0;
                end
            end else if (d == 0) begin
                m_locked = 1;
                m_pos    = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("locked", locked, m_locked);
        check("expected", expected, m_exp());
        check("match", match, m_match);
        check("err", err, m_err);
        check("err_sticky", err_sticky, m_sticky);
        check("err_count", err_count, m_errs);
        check("period_done", period_done, m_pd);
        check("periods", periods, m_pers);
        if (m_locked) begin
            check("dir", dir, (m_pos >= 57) ? 1 : 0);
            check("step", step, (m_pos < 57) ? m_pos + 1 : m_pos - 57);
        end
    endtask

    task automatic drive(input bit v, input logic [5:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        model_step(v, int'(d));
        compare_all();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 6'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_locked = 0; m_sticky = 0; m_match = 0; m_err = 0; m_pd = 0;
        m_pos = 0; m_errs = 0; m_pers = 0;
        compare_all();
        check("rst_dir", dir, 0);
        check("rst_step", step, 1);
    endtask

    int  mc;
    bit  v;
    int  r;
    logic [5:0] d;

    initial begin
        build_seq();
        rst = 1'b1; in_valid = 1'b0; in_data = 6'd0;
        do_reset();

        // Lock and first five predictions
        mc = 0;
        drive(1, 6'd0);
        foreach (down_tbl[i]) if (i < 5) begin
            case (i)
                0: d = 6'd1;
                1: d = 6'd3;
                2: d = 6'd6;
                3: d = 6'd2;
                default: d = 6'd7;
            endcase
            drive(1, d);
            mc += int'(match);
        end
        check("lock_matches", mc, 5);
        check("exp_after_7", expected, 1);
        check("lock_errs", err_count, 0);

        // Two golden periods
        do_reset();
        drive(1, 6'd0);
        for (int i = 0; i < 126; i++) begin
            if (m_locked && m_pos >= 57) check("down_exp", expected, down_tbl[m_pos - 57]);
            drive(1, 6'(seq[i % 63]));
        end
        check("two_periods", periods, 2);
        check("golden_sticky", err_sticky, 0);

        // Same stream with idle gaps between samples
        do_reset();
        drive(1, 6'd0);
        mc = 0;
        for (int i = 0; i < 126; i++) begin
            drive(0, 6'($urandom_range(0, 63)));
            drive(1, 6'(seq[i % 63]));
            mc += int'(match);
        end
        check("gap_matches", mc, 126);
        check("gap_periods", periods, 2);

        // Periods saturate
        drive(1, 6'(seq[0]));
        for (int i = 1; i < 3 * 63; i++) drive(1, 6'(seq[i % 63]));
        check("per_sat", periods, PMAX);

        // Injected mismatch, then relock on a following 0
        do_reset();
        drive(1, 6'd0); drive(1, 6'd1); drive(1, 6'd3);
        drive(1, 6'd5);
        check("inj_err", err, 1);
        check("inj_cnt", err_count, 1);
        check("inj_unlock", locked, 0);
        drive(1, 6'd0);
        check("inj_relock", locked, 1);

        // Mismatching 0 relocks immediately
        do_reset();
        drive(1, 6'd0); drive(1, 6'd1); drive(1, 6'd3); drive(1, 6'd6);
        drive(1, 6'd0);
        check("z_err", err, 1);
        check("z_locked", locked, 1);
        drive(1, 6'd1);
        check("z_match", match, 1);

        // Error counter saturates
        do_reset();
        for (int i = 0; i < 10; i++) drive(1, 6'd0);
        check("err_sat", err_count, EMAX);

        // Reset in the down phase
        do_reset();
        drive(1, 6'd0);
        for (int i = 0; i < 60; i++) drive(1, 6'(seq[i]));
        check("pre_rst_dir", dir, 1);
        do_reset();
        drive(1, 6'd48);
        check("post_rst_err", err, 0);
        check("post_rst_lock", locked, 0);

        // Randomised traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 999);
            if (m_locked) d = (r < 985) ? 6'(seq[m_pos]) : ((r < 992) ? 6'd0 : 6'($urandom_range(0, 63)));
            else          d = (r < 300) ? 6'd0 : 6'($urandom_range(0, 63));
            drive(v, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
